// File: rtl/pixel_capture_pkg.sv
// Shared definitions for the 28x28 ROI capture controller: FSM states,
// Avalon register offsets and CTRL/STATUS bit positions.
package pixel_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [10:0] REG_CTRL   = 11'h000;
  localparam logic [10:0] REG_ORIGIN = 11'h001;
  localparam logic [10:0] REG_DECIM  = 11'h002;
  localparam logic [10:0] REG_THRESH = 11'h003;
  localparam logic [10:0] BUF_BASE   = 11'h400;

  // CTRL write bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_CLR_DONE = 3;

  // CTRL read (status) bits
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_ERR    = 2;
  localparam int unsigned STAT_IRQ_EN = 3;

  localparam logic [3:0] DECIM_RST  = 4'd1;
  localparam logic [7:0] THRESH_RST = 8'h80;

endpackage

// File: rtl/pixel_capture_buf.sv
// Simple dual-port ROI byte buffer: camera-side write port, CPU-side
// registered read port. Written so it maps onto a single block RAM.
module pixel_capture_buf #(
  parameter int unsigned DEPTH = 784,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_capture_ctrl.sv
// ROI capture sequencer with Avalon-MM slave. Optional input thresholding
// is enabled by defining PIXEL_CAPTURE_THRESH_EN.
module pixel_capture_ctrl
  import pixel_capture_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CNT_W = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic [7:0]  cam_pix,
  input  logic        cam_valid,
  input  logic        cam_frame_start,
  input  logic        cam_line_start,
  output logic        irq
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(IMG_W + 1);
  localparam int unsigned YW   = $clog2(IMG_H + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;
  logic done_q, done_d, err_q, err_d, irq_en_q;
  logic [CNT_W-1:0] x0_q, y0_q, step_m1;
  logic [3:0] decim_q;
`ifdef PIXEL_CAPTURE_THRESH_EN
  logic [7:0] thresh_q;
`endif

  logic wr_ctrl, start, abort, clr_done, busy;
  assign wr_ctrl  = avs_write && (avs_address == REG_CTRL);
  assign start    = wr_ctrl && avs_writedata[CTRL_START];
  assign abort    = wr_ctrl && avs_writedata[CTRL_ABORT];
  assign clr_done = wr_ctrl && avs_writedata[CTRL_CLR_DONE];
  assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
  assign irq      = done_q & irq_en_q;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= '0;
      y0_q     <= '0;
      decim_q  <= DECIM_RST;
      irq_en_q <= 1'b0;
`ifdef PIXEL_CAPTURE_THRESH_EN
      thresh_q <= THRESH_RST;
`endif
    end else if (avs_write) begin
      case (avs_address)
        REG_CTRL:   irq_en_q <= avs_writedata[CTRL_IRQ_EN];
        REG_ORIGIN: begin
          x0_q <= avs_writedata[CNT_W-1:0];
          y0_q <= avs_writedata[16+CNT_W-1:16];
        end
        REG_DECIM:  decim_q <= avs_writedata[3:0];
`ifdef PIXEL_CAPTURE_THRESH_EN
        REG_THRESH: thresh_q <= avs_writedata[7:0];
`endif
        default: ;
      endcase
    end
  end

  assign step_m1 = (decim_q == 4'd0) ? '0 : CNT_W'(decim_q - 4'd1);

  // Phase counters: each wait counter counts down to the next sampled
  // line/column, so col = X0 + i*DECIM is found without a divider.
  logic [CNT_W-1:0] x_wait_q, y_wait_q;
  logic [XW-1:0]    xi_q;
  logic [YW-1:0]    yj_q, cur_j_q;
  logic             row_sel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_wait_q  <= '0;
      y_wait_q  <= '0;
      xi_q      <= '0;
      yj_q      <= '0;
      cur_j_q   <= '0;
      row_sel_q <= 1'b0;
    end else begin
      if (cam_frame_start) begin
        y_wait_q  <= y0_q;
        yj_q      <= '0;
        row_sel_q <= 1'b0;
      end else if (cam_line_start) begin
        if (y_wait_q == '0) begin
          y_wait_q  <= step_m1;
          row_sel_q <= (yj_q < YW'(IMG_H));
          cur_j_q   <= yj_q;
          if (yj_q < YW'(IMG_H)) yj_q <= yj_q + YW'(1);
        end else begin
          y_wait_q  <= y_wait_q - CNT_ONE;
          row_sel_q <= 1'b0;
        end
      end
      if (cam_line_start) begin
        x_wait_q <= x0_q;
        xi_q     <= '0;
      end else if (cam_valid) begin
        if (x_wait_q == '0) begin
          x_wait_q <= step_m1;
          if (xi_q < XW'(IMG_W)) xi_q <= xi_q + XW'(1);
        end else begin
          x_wait_q <= x_wait_q - CNT_ONE;
        end
      end
    end
  end

  logic          sample;
  logic [AW-1:0] pix_idx;
  logic [7:0]    pix_val;
  assign sample  = cam_valid && !cam_line_start && row_sel_q && (x_wait_q == '0)
                   && (xi_q < XW'(IMG_W)) && (state_q == CAPTURE);
  assign pix_idx = AW'(cur_j_q) * AW'(IMG_W) + AW'(xi_q);
`ifdef PIXEL_CAPTURE_THRESH_EN
  assign pix_val = (cam_pix >= thresh_q) ? 8'hFF : 8'h00;
`else
  assign pix_val = cam_pix;
`endif

  logic          wr_en_q, last_write, buf_wr_en;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= sample;
      wr_addr_q <= pix_idx;
      wr_data_q <= pix_val;
    end
  end

  // Writes still in flight when CAPTURE is left (abort) are dropped.
  assign buf_wr_en  = wr_en_q && (state_q == CAPTURE);
  assign last_write = buf_wr_en && (wr_addr_q == AW'(NPIX - 1));

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clr_done) done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      done_d  = done_q;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ARMED;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
        ARMED: if (cam_frame_start) state_d = CAPTURE;
        CAPTURE: begin
          if (last_write) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (cam_frame_start) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_d = ARMED;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else if (clr_done) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Read path: registers and buffer both land one cycle after avs_read.
  logic [10:0] buf_off;
  logic        buf_hit, rd_buf_q;
  logic [31:0] reg_rd, reg_rd_q;
  logic [7:0]  ram_q;

  assign buf_off = avs_address - BUF_BASE;
  assign buf_hit = (avs_address >= BUF_BASE) && (32'(buf_off) < NPIX);

  always_comb begin
    reg_rd = '0;
    case (avs_address)
      REG_CTRL: begin
        reg_rd[STAT_BUSY]   = busy;
        reg_rd[STAT_DONE]   = done_q;
        reg_rd[STAT_ERR]    = err_q;
        reg_rd[STAT_IRQ_EN] = irq_en_q;
      end
      REG_ORIGIN: begin
        reg_rd[CNT_W-1:0]     = x0_q;
        reg_rd[16+CNT_W-1:16] = y0_q;
      end
      REG_DECIM:  reg_rd[3:0] = decim_q;
`ifdef PIXEL_CAPTURE_THRESH_EN
      REG_THRESH: reg_rd[7:0] = thresh_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_buf_q <= 1'b0;
      reg_rd_q <= '0;
    end else if (avs_read) begin
      rd_buf_q <= buf_hit;
      reg_rd_q <= reg_rd;
    end
  end

  assign avs_readdata = rd_buf_q ? {24'h0, ram_q} : reg_rd_q;

  pixel_capture_buf #(
    .DEPTH(NPIX),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_wr_en),
    .wr_addr(wr_addr_q),
    .wr_data(wr_data_q),
    .rd_en  (avs_read && buf_hit),
    .rd_addr(buf_off[AW-1:0]),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_pixel_capture_ctrl.sv
// Scoreboard bench for pixel_capture_ctrl: reads push expected data, a
// monitor pops and compares when read data is presented.
`timescale 1ns/1ps
module tb_pixel_capture_ctrl;
  import pixel_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic [7:0]  cam_pix;
  logic        cam_valid, cam_frame_start, cam_line_start, irq;

  always #5 clk = ~clk;

  pixel_capture_ctrl #(
    .IMG_W(28),
    .IMG_H(28),
    .CNT_W(12)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .cam_pix        (cam_pix),
    .cam_valid      (cam_valid),
    .cam_frame_start(cam_frame_start),
    .cam_line_start (cam_line_start),
    .irq            (irq)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: read data is valid on the half cycle after the read edge.
  initial begin
    forever begin
      logic pend;
      exp_t e;
      @(posedge clk);
      pend = avs_read;
      @(negedge clk);
      if (pend) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got 0x%08h expected no read", avs_readdata);
        end else begin
          e = sbq.pop_front();
          check(e.name, avs_readdata, e.exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [10:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    sbq.push_back('{exp, name});
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    @(negedge clk);
    check(name, 32'(irq), 32'(exp));
  endtask

  task automatic cam_frame_pulse();
    @(negedge clk);
    cam_frame_start = 1'b1;
    @(negedge clk);
    cam_frame_start = 1'b0;
  endtask

  // Lines first..first+n-1, width w, pixel = (col + row + off) & 0xFF
  task automatic cam_lines(input int first, input int n, input int w, input int off);
    for (int r = first; r < first + n; r++) begin
      @(negedge clk);
      cam_line_start = 1'b1;
      @(negedge clk);
      cam_line_start = 1'b0;
      for (int c = 0; c < w; c++) begin
        cam_valid = 1'b1;
        cam_pix   = 8'(c + r + off);
        @(negedge clk);
      end
      cam_valid = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    cam_pix = '0; cam_valid = 1'b0; cam_frame_start = 1'b0; cam_line_start = 1'b0;
    #12;
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    #11 reset_n = 1'b1;

    // Reset register values and unmapped reads
    bus_read(REG_CTRL,   32'h0, "rst_ctrl");
    bus_read(REG_ORIGIN, 32'h0, "rst_origin");
    bus_read(REG_DECIM,  32'h1, "rst_decim");
`ifdef PIXEL_CAPTURE_THRESH_EN
    bus_read(REG_THRESH, 32'h80, "rst_thresh");
`else
    bus_read(REG_THRESH, 32'h0, "rst_thresh_absent");
`endif
    bus_read(11'h004, 32'h0, "unmapped_reg");
    bus_read(11'h710, 32'h0, "unmapped_buf_end");
    check_irq(1'b0, "rst_irq_run");

    // Offset ROI, decimation 1, 64x40 frame
    bus_write(REG_ORIGIN, (32'd5 << 16) | 32'd10);
    bus_write(REG_DECIM, 32'd1);
    bus_write(REG_CTRL, 32'h5);
    bus_read(REG_ORIGIN, 32'h0005_000A, "origin_rb");
    bus_read(REG_CTRL, 32'h9, "armed_busy");
    cam_frame_pulse();
    cam_lines(0, 40, 64, 0);
    bus_read(REG_CTRL, 32'hA, "t2_done");
    check_irq(1'b1, "t2_irq");
    bus_read(BUF_BASE + 11'd0,   32'd15, "t2_buf0");
    bus_read(BUF_BASE + 11'd29,  32'd17, "t2_buf29");
    bus_read(BUF_BASE + 11'd783, 32'd69, "t2_buf783");

    // Decimation 2 from the origin, 64x56 frame
    bus_write(REG_DECIM, 32'd2);
    bus_write(REG_ORIGIN, 32'd0);
    bus_write(REG_CTRL, 32'h5);
    bus_read(REG_CTRL, 32'h9, "t3_restart_clears");
    check_irq(1'b0, "t3_irq_cleared");
    cam_frame_pulse();
    cam_lines(0, 56, 64, 0);
    bus_read(REG_CTRL, 32'hA, "t3_done");
    bus_read(BUF_BASE + 11'd1,   32'd2,   "t3_buf1");
    bus_read(BUF_BASE + 11'd28,  32'd2,   "t3_buf28");
    bus_read(BUF_BASE + 11'd783, 32'd108, "t3_buf783");

    // CLR_DONE returns to IDLE and drops irq
    bus_write(REG_CTRL, 32'hC);
    bus_read(REG_CTRL, 32'h8, "clr_done_ctrl");
    check_irq(1'b0, "clr_done_irq");

    // START with a coincident frame_start: that frame_start is not used
    bus_write(REG_DECIM, 32'd1);
    @(negedge clk);
    avs_address = REG_CTRL; avs_writedata = 32'h5; avs_write = 1'b1; cam_frame_start = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; cam_frame_start = 1'b0;
    cam_lines(0, 30, 30, 0);
    bus_read(REG_CTRL, 32'h9, "start_fs_same_cycle");

    // Short frame (20 lines) then next frame_start -> ERR
    cam_frame_pulse();
    cam_lines(0, 20, 64, 0);
    bus_read(REG_CTRL, 32'h9, "short_still_busy");
    check_irq(1'b0, "short_irq_low");
    cam_frame_pulse();
    bus_read(REG_CTRL, 32'hE, "short_err");
    check_irq(1'b1, "short_irq");
    bus_read(BUF_BASE + 11'd537, 32'd24, "short_buf537");

    // ABORT mid-capture: no writes afterwards
    bus_write(REG_CTRL, 32'h5);
    cam_frame_pulse();
    cam_lines(0, 5, 64, 8'h80);
    bus_write(REG_CTRL, 32'h6);
    bus_read(REG_CTRL, 32'h8, "abort_idle");
    check_irq(1'b0, "abort_irq");
    cam_lines(5, 10, 64, 8'h80);
    bus_read(REG_CTRL, 32'h8, "abort_stays_idle");
    bus_read(BUF_BASE + 11'd0,   32'h80, "abort_buf0");
    bus_read(BUF_BASE + 11'd114, 32'h86, "abort_buf114");
    bus_read(BUF_BASE + 11'd283, 32'd13, "abort_buf283_old");

    // Threshold (or raw) with DECIM=0 acting as 1, exactly 28x28 frame
    bus_write(REG_THRESH, 32'h40);
`ifdef PIXEL_CAPTURE_THRESH_EN
    bus_read(REG_THRESH, 32'h40, "thresh_rb");
`else
    bus_read(REG_THRESH, 32'h0, "thresh_ignored");
`endif
    bus_write(REG_DECIM, 32'd0);
    bus_read(REG_DECIM, 32'd0, "decim0_rb");
    bus_write(REG_CTRL, 32'h5);
    cam_frame_pulse();
    cam_lines(0, 28, 28, 8'h3F);
    bus_read(REG_CTRL, 32'hA, "exact_fit_done");
`ifdef PIXEL_CAPTURE_THRESH_EN
    bus_read(BUF_BASE + 11'd0,   32'h00, "thr_below");
    bus_read(BUF_BASE + 11'd1,   32'hFF, "thr_equal");
    bus_read(BUF_BASE + 11'd783, 32'hFF, "thr_last");
`else
    bus_read(BUF_BASE + 11'd0,   32'h3F, "raw_buf0");
    bus_read(BUF_BASE + 11'd1,   32'h40, "raw_buf1");
    bus_read(BUF_BASE + 11'd783, 32'h75, "raw_buf783");
`endif

    repeat (5) @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_capture_ctrl.md
# pixel_capture_ctrl

Sequences capture of one 28×28 region of interest from the 8-bit camera pixel stream into an on-chip buffer and exposes it to the Nios II CPU as an Avalon-MM slave. It replaces polled per-pixel PIO reads: software arms a capture, waits for DONE or IRQ, then reads 784 bytes for MNIST inference. It sits between the camera pixel/sync stream and the system interconnect.

## Interface
- IMG_W, 28, ROI width in samples
- IMG_H, 28, ROI height in samples
- CNT_W, 12, width of camera column/row counters
- clk  in  1  system clock; camera stream is already synchronous to it
- reset_n  in  1  reset, asynchronous, active-low
- avs_address  in  11  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data, fixed read latency 1
- cam_pix  in  8  pixel value
- cam_valid  in  1  cam_pix valid this cycle
- cam_frame_start  in  1  one-cycle pulse before the first line of a frame
- cam_line_start  in  1  one-cycle pulse before the first pixel of each line
- irq  out  1  level interrupt = DONE & IRQ_EN

## Operation
- Register map (word addresses):
  - 0x000 CTRL: write bit0 START, bit1 ABORT, bit2 IRQ_EN (sticky), bit3 CLR_DONE. Read bit0 BUSY, bit1 DONE, bit2 ERR, bit3 IRQ_EN.
  - 0x001 ORIGIN: [CNT_W-1:0] X0, [16+CNT_W-1:16] Y0.
  - 0x002 DECIM: [3:0] step, 0 treated as 1.
  - 0x003 THRESH: [7:0], present only with the threshold feature.
  - 0x400–0x70F: buffer, index = row·IMG_W + col, byte in [7:0], upper bits 0. Reads of unmapped addresses return 0.
- Counters: col resets to 0 on cam_line_start and increments on each cam_valid. row is set to all-ones on cam_frame_start and increments on cam_line_start, so the first line is row 0.
- A pixel is sampled when col = X0 + i·DECIM and row = Y0 + j·DECIM, for i < IMG_W and j < IMG_H. Phase counters implement this; no divider. It is written at index j·IMG_W + i.
- FSM:
  - IDLE: START → ARMED.
  - ARMED: cam_frame_start → CAPTURE.
  - CAPTURE: write index 783 → DONE. A cam_frame_start before index 783 sets ERR → DONE.
  - DONE: START → ARMED, which clears DONE and ERR. CLR_DONE → IDLE.
  - ABORT in any state → IDLE. DONE and ERR are unchanged.
- BUSY = ARMED or CAPTURE. START while BUSY is ignored.
- If the ROI extends past the camera line/frame, missing samples are never written. Completion then comes only via the next frame_start, which sets ERR.
- CPU buffer reads during CAPTURE are permitted and return stale or partial data.

## Timing
- Reset values: avs_readdata = 0, irq = 0, state IDLE, DONE = ERR = IRQ_EN = 0, ORIGIN = 0, DECIM = 1, THRESH = 0x80. Buffer contents are undefined.
- Read data appears on the cycle after avs_read. Write side effects take effect the cycle after avs_write.
- Sample to buffer write: 1 cycle. DONE and irq assert 1 cycle after the final write.
- cam_frame_start in the same cycle as START while IDLE: the START is taken and that frame_start is not used. Capture begins at the next frame.
- ABORT together with START: ABORT wins.
- reset_n deassertion mid-frame: the FSM stays IDLE until START, then waits for a full frame_start.

## Configuration
- PIXEL_CAPTURE_THRESH_EN defined: the THRESH register exists. Stored byte = (cam_pix ≥ THRESH) ? 8'hFF : 8'h00.
- PIXEL_CAPTURE_THRESH_EN undefined: raw cam_pix is stored. Address 0x003 reads 0 and ignores writes.

## Structure
- Package pixel_capture_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE)
  - register offset constants and the buffer base 0x400
  - the CTRL/STATUS bit positions
- Sub-module pixel_capture_buf: simple dual-port RAM of IMG_W·IMG_H × 8 with a camera-side write port and a CPU-side registered read port, inferable as M9K.

## Test plan
- Reset, then read CTRL → 0x0, ORIGIN → 0, DECIM → 1, irq = 0.
- ORIGIN X0=10 Y0=5, DECIM=1, START; 64×40 frame with pix = (col+row)&0xFF → DONE=1, ERR=0; buffer[0] = 15, buffer[783] = 69.
- DECIM=2, X0=Y0=0, same pattern → buffer[1] = 2, buffer[28] = 2, buffer[783] = 108.
- Frame only 20 lines tall, then the next frame_start → DONE=1, ERR=1, irq=1 if IRQ_EN.
- START, then ABORT mid-CAPTURE → BUSY=0, no further buffer writes; CLR_DONE → irq=0.
- With PIXEL_CAPTURE_THRESH_EN and THRESH=0x40: pix 0x3F → 0x00, pix 0x40 → 0xFF.
